// File: rtl/addsub_rr_sched_pkg.sv
// rtl/addsub_rr_sched_pkg.sv - shared types and helpers for the add/sub round-robin scheduler
//
// Contents:
//   sched_state_t : scheduler FSM states (IDLE, EXEC, RESP)
//   id_width()    : width of a requester index for a given requester count
//   rsp_t         : response bundle {id, sum, cout[, ovf]} at the default N=32, NREQ=4 sizing
// Optional feature macro: ADDSUB_RR_SCHED_OVF_EN adds the ovf field to rsp_t.
package addsub_rr_sched_pkg;

    localparam int RSP_N    = 32;
    localparam int RSP_NREQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    // A single requester still needs a 1-bit index so ports never collapse to zero width.
    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    localparam int RSP_ID_W = id_width(RSP_NREQ);

    typedef struct packed {
        logic [RSP_ID_W-1:0] id;
        logic [RSP_N-1:0]    sum;
        logic                cout;
`ifdef ADDSUB_RR_SCHED_OVF_EN
        logic                ovf;
`endif
    } rsp_t;

endpackage

// File: rtl/addsub_rr_scheduler_rr_arbiter.sv
// rtl/addsub_rr_scheduler_rr_arbiter.sv - combinational round-robin arbiter
//
// Ports:
//   req       : request vector (NREQ bits)
//   ptr       : highest-priority index; search runs upward from here modulo NREQ
//   grant     : one-hot grant, zero when no request
//   grant_idx : encoded index of the granted requester (0 when none)
//   grant_any : at least one request present
module rr_arbiter
    import addsub_rr_sched_pkg::*;
#(
    parameter int  NREQ = 4,
    localparam int ID_W = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            grant_any
);

    logic [ID_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % NREQ);
            if (!grant_any && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                grant_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ripple_carry_adder_subtractor.sv
// rtl/ripple_carry_adder_subtractor.sv - N-bit ripple-carry adder/subtractor
//
// Ports:
//   a, b : operands (N bits)
//   cin  : carry in; also the subtract select (1 = a - b computed as a + ~b + 1)
//   s    : sum (N bits, modulo 2^N)
//   cout : carry out (for subtract: 1 = no borrow)
module ripple_carry_adder_subtractor #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N-1:0] bx;
    logic [N:0]   c;

    // cin both inverts b and supplies the +1, giving two's-complement subtraction.
    assign bx   = b ^ {N{cin}};
    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i]   = a[i] ^ bx[i] ^ c[i];
        assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end

    assign cout = c[N];

endmodule

// File: rtl/addsub_rr_scheduler.sv
// rtl/addsub_rr_scheduler.sv - round-robin sharing of one adder/subtractor among NREQ requesters
//
// Ports:
//   clk, rst   : clock; asynchronous active-high reset
//   req_valid  : per-requester request valid (NREQ)
//   req_ready  : per-requester accept, one-hot or zero, combinational in IDLE
//   req_sub    : per-requester op select (1 = a - b)
//   req_a/b    : packed operands, requester i at [i*N +: N]
//   rsp_valid  : result held valid in RESP
//   rsp_ready  : consumer accepts result
//   rsp_id     : requester index owning the result
//   rsp_sum    : result
//   rsp_cout   : carry out (subtract: 1 = no borrow)
//   rsp_ovf    : signed overflow, present only with ADDSUB_RR_SCHED_OVF_EN defined
// Flow: IDLE (grant + latch operands) -> EXEC (adder runs from registers) -> RESP (hold).
module addsub_rr_scheduler
    import addsub_rr_sched_pkg::*;
#(
    parameter int  N    = 32,
    parameter int  NREQ = 4,
    localparam int ID_W = id_width(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [NREQ-1:0] req_sub,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic            rsp_valid,
    output logic [ID_W-1:0] rsp_id,
    output logic [N-1:0]    rsp_sum,
    output logic            rsp_cout,
`ifdef ADDSUB_RR_SCHED_OVF_EN
    output logic            rsp_ovf,
`endif
    input  logic            rsp_ready
);

    sched_state_t    state, state_nxt;
    logic [ID_W-1:0] ptr;
    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] grant_idx;
    logic            grant_any;
    logic            handshake;

    logic [N-1:0]    op_a, op_b;
    logic            op_sub;
    logic [ID_W-1:0] op_id;

    logic [N-1:0]    add_s;
    logic            add_cout;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // The adder only ever sees registered operands, so its ripple chain has a full cycle.
    ripple_carry_adder_subtractor #(.N(N)) u_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_sub),
        .s    (add_s),
        .cout (add_cout)
    );

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        handshake = 1'b0;
        unique case (state)
            IDLE: begin
                // Masked during reset so req_ready reads zero while rst is held.
                if (!rst) begin
                    req_ready = grant;
                end
                if (grant_any) begin
                    handshake = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);

`ifdef ADDSUB_RR_SCHED_OVF_EN
    logic [N-1:0] op_bx;
    logic         ovf_calc;
    assign op_bx    = op_b ^ {N{op_sub}};
    assign ovf_calc = (op_a[N-1] == op_bx[N-1]) && (add_s[N-1] != op_a[N-1]);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_sub   <= 1'b0;
            op_id    <= '0;
            rsp_id   <= '0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
`ifdef ADDSUB_RR_SCHED_OVF_EN
            rsp_ovf  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (handshake) begin
                ptr    <= (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                op_a   <= req_a[int'(grant_idx)*N +: N];
                op_b   <= req_b[int'(grant_idx)*N +: N];
                op_sub <= req_sub[grant_idx];
                op_id  <= grant_idx;
            end
            if (state == EXEC) begin
                rsp_sum  <= add_s;
                rsp_cout <= add_cout;
                rsp_id   <= op_id;
`ifdef ADDSUB_RR_SCHED_OVF_EN
                rsp_ovf  <= ovf_calc;
`endif
            end
        end
    end

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// tb/tb_addsub_rr_scheduler.sv - self-checking bench for addsub_rr_scheduler
module tb_addsub_rr_scheduler;

    localparam int N    = 32;
    localparam int NREQ = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [NREQ-1:0] req_sub;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [N-1:0]    rsp_sum;
    logic            rsp_cout;
`ifdef ADDSUB_RR_SCHED_OVF_EN
    logic            rsp_ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int ptr_m   = 0;

    always #5 clk = ~clk;

    addsub_rr_scheduler #(.N(N), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sub   (req_sub),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
`ifdef ADDSUB_RR_SCHED_OVF_EN
        .rsp_ovf   (rsp_ovf),
`endif
        .rsp_ready (rsp_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {cout, sum}: add is a 33-bit sum; subtract wraps and carries out iff no borrow.
    function automatic logic [32:0] ref_result(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [32:0] r;
        if (!sub) begin
            r = {1'b0, a} + {1'b0, b};
        end else begin
            r[31:0] = a - b;
            r[32]   = (a >= b);
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b, input logic sub);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = sub ? (sa - sb) : (sa + sb);
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    function automatic int model_grant(input logic [3:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic randomize_operands();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = $urandom;
            req_b[i*N +: N] = $urandom;
        end
        req_sub = 4'($urandom_range(0, 15));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0; req_sub = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        n_tests++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_tests++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
        n_tests++; if (rsp_sum !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_sum: got %h expected 0", rsp_sum); end
        n_tests++; if (rsp_cout !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_cout: got %b expected 0", rsp_cout); end
`ifdef ADDSUB_RR_SCHED_OVF_EN
        n_tests++; if (rsp_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_ovf: got %b expected 0", rsp_ovf); end
`endif
        ptr_m = 0;
    endtask

    task automatic test_directed();
        int          did[6]  = '{0, 1, 1, 2, 3, 3};
        logic [31:0] da[6]   = '{32'd5, 32'd5, 32'd7, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
        logic [31:0] db[6]   = '{32'd7, 32'd7, 32'd5, 32'd1, 32'd1, 32'd1};
        logic        dsub[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] dsum[6] = '{32'd12, 32'hFFFFFFFE, 32'd2, 32'd0, 32'h80000000, 32'h7FFFFFFF};
        logic        dco[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        dov[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0]  exp_rdy;
        for (int t = 0; t < 6; t++) begin
            req_a = '0; req_b = '0; req_sub = '0;
            req_a[did[t]*N +: N] = da[t];
            req_b[did[t]*N +: N] = db[t];
            req_sub[did[t]]      = dsub[t];
            req_valid = 4'(1 << did[t]);
            exp_rdy   = 4'(1 << did[t]);
            #1;
            n_tests++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL dir%0d_grant: got %b expected %b", t, req_ready, exp_rdy); end
            tick();
            // Operand changes after the handshake must not matter.
            randomize_operands();
            req_valid = 4'($urandom_range(0, 15));
            #1;
            n_tests++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0) begin n_fail++; $display("FAIL dir%0d_exec: got valid=%b ready=%b expected valid=0 ready=0000", t, rsp_valid, req_ready); end
            tick();
            n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_latency: got valid=%b expected 1", t, rsp_valid); end
            n_tests++; if (rsp_id !== 2'(did[t])) begin n_fail++; $display("FAIL dir%0d_id: got %0d expected %0d", t, rsp_id, did[t]); end
            n_tests++; if (rsp_sum !== dsum[t] || rsp_cout !== dco[t]) begin n_fail++; $display("FAIL dir%0d_sum: got %h/%b expected %h/%b", t, rsp_sum, rsp_cout, dsum[t], dco[t]); end
`ifdef ADDSUB_RR_SCHED_OVF_EN
            n_tests++; if (rsp_ovf !== dov[t]) begin n_fail++; $display("FAIL dir%0d_ovf: got %b expected %b", t, rsp_ovf, dov[t]); end
`else
            if (dov[t] === 1'bx) $display("unused %b", dov[t]);
`endif
            rsp_ready = 1'b1;
            req_valid = '0;
            tick();
            rsp_ready = 1'b0;
            ptr_m = (did[t] + 1) % NREQ;
        end
    endtask

    task automatic test_random();
        logic [3:0]  mask;
        int          g;
        logic [31:0] ea, eb;
        logic        es;
        logic [32:0] er;
        for (int it = 0; it < 60; it++) begin
            randomize_operands();
            mask = 4'($urandom_range(0, 15));
            req_valid = mask;
            #1;
            g = model_grant(mask, ptr_m);
            n_tests++; if (req_ready !== ((g < 0) ? 4'b0 : 4'(1 << g))) begin n_fail++; $display("FAIL rnd%0d_grant: got %b mask %b ptr %0d model %0d", it, req_ready, mask, ptr_m, g); end
            if (g < 0) begin
                tick();
                continue;
            end
            ea = req_a[g*N +: N]; eb = req_b[g*N +: N]; es = req_sub[g];
            er = ref_result(ea, eb, es);
            ptr_m = (g + 1) % NREQ;
            tick();
            randomize_operands();
            req_valid = 4'($urandom_range(0, 15));
            tick();
            n_tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g)) begin n_fail++; $display("FAIL rnd%0d_rsp: got valid=%b id=%0d expected valid=1 id=%0d", it, rsp_valid, rsp_id, g); end
            n_tests++; if ({rsp_cout, rsp_sum} !== er) begin n_fail++; $display("FAIL rnd%0d_sum: got %b/%h expected %b/%h", it, rsp_cout, rsp_sum, er[32], er[31:0]); end
`ifdef ADDSUB_RR_SCHED_OVF_EN
            n_tests++; if (rsp_ovf !== ref_ovf(ea, eb, es)) begin n_fail++; $display("FAIL rnd%0d_ovf: got %b expected %b", it, rsp_ovf, ref_ovf(ea, eb, es)); end
`endif
            for (int s = 0; s < int'($urandom_range(0, 3)); s++) begin
                req_valid = 4'($urandom_range(0, 15));
                tick();
                n_tests++; if (rsp_valid !== 1'b1 || req_ready !== 4'b0 || {rsp_cout, rsp_sum} !== er) begin n_fail++; $display("FAIL rnd%0d_stall: got valid=%b ready=%b sum=%h", it, rsp_valid, req_ready, rsp_sum); end
            end
            rsp_ready = 1'b1;
            req_valid = '0;
            tick();
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int          cyc = 0;
        int          k = 0;
        int          first = -1;
        int          qid[$];
        logic [32:0] qres[$];
        int          gi;
        logic [32:0] r;
        rst = 1'b1; tick(); rst = 1'b0; ptr_m = 0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        while ((k < 8 || qid.size() > 0) && cyc < 60) begin
            if (k >= 8) req_valid = '0;
            randomize_operands();
            #1;
            if (rsp_valid) begin
                if (qid.size() == 0) begin
                    n_fail++; n_tests++; $display("FAIL b2b_spurious: got rsp_valid=1 expected no response");
                end else begin
                    gi = qid.pop_front(); r = qres.pop_front();
                    n_tests++; if (rsp_id !== 2'(gi) || {rsp_cout, rsp_sum} !== r) begin n_fail++; $display("FAIL b2b_rsp: got id=%0d %b/%h expected id=%0d %b/%h", rsp_id, rsp_cout, rsp_sum, gi, r[32], r[31:0]); end
                end
            end
            if (req_ready != 4'b0) begin
                n_tests++; if (req_ready !== 4'(1 << (k % 4))) begin n_fail++; $display("FAIL b2b_order%0d: got %b expected %b", k, req_ready, 4'(1 << (k % 4))); end
                if (first < 0) first = cyc;
                n_tests++; if (cyc != first + 3 * k) begin n_fail++; $display("FAIL b2b_cycle%0d: got %0d expected %0d", k, cyc, first + 3 * k); end
                qid.push_back(k % 4);
                qres.push_back(ref_result(req_a[(k%4)*N +: N], req_b[(k%4)*N +: N], req_sub[k%4]));
                k++;
            end
            tick();
            cyc++;
        end
        n_tests++; if (k != 8 || qid.size() != 0) begin n_fail++; $display("FAIL b2b_timeout: got %0d grants %0d pending expected 8 grants 0 pending", k, qid.size()); end
        rsp_ready = 1'b0;
        req_valid = '0;
        ptr_m = 0;
    endtask

    task automatic test_stall();
        int          g;
        logic [32:0] er;
        randomize_operands();
        req_valid = 4'b1111;
        #1;
        g = model_grant(4'b1111, ptr_m);
        n_tests++; if (req_ready !== 4'(1 << g)) begin n_fail++; $display("FAIL stall_grant: got %b expected %b", req_ready, 4'(1 << g)); end
        er = ref_result(req_a[g*N +: N], req_b[g*N +: N], req_sub[g]);
        ptr_m = (g + 1) % NREQ;
        tick(); tick();
        for (int s = 0; s < 10; s++) begin
            randomize_operands();
            #1;
            n_tests++; if (rsp_valid !== 1'b1 || req_ready !== 4'b0 || rsp_id !== 2'(g) || {rsp_cout, rsp_sum} !== er) begin n_fail++; $display("FAIL stall_hold%0d: got valid=%b ready=%b id=%0d sum=%h expected 1/0000/%0d/%h", s, rsp_valid, req_ready, rsp_id, rsp_sum, g, er[31:0]); end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        g = model_grant(4'b1111, ptr_m);
        n_tests++; if (req_ready !== 4'(1 << g)) begin n_fail++; $display("FAIL stall_release_grant: got %b expected %b", req_ready, 4'(1 << g)); end
        ptr_m = (g + 1) % NREQ;
        req_valid = '0;
        tick(); tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_rst_mid();
        randomize_operands();
        req_valid = 4'b0100;
        #1;
        n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rstmid_grant: got %b expected 0100", req_ready); end
        tick();
        req_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        n_tests++; if (rsp_valid !== 1'b0 || rsp_sum !== 32'd0 || rsp_cout !== 1'b0 || rsp_id !== 2'd0 || req_ready !== 4'b0) begin n_fail++; $display("FAIL rstmid_async: got valid=%b sum=%h cout=%b id=%0d ready=%b expected all 0", rsp_valid, rsp_sum, rsp_cout, rsp_id, req_ready); end
        tick();
        rst = 1'b0;
        ptr_m = 0;
        for (int s = 0; s < 4; s++) begin
            tick();
            n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_rsp%0d: got valid=%b expected 0", s, rsp_valid); end
        end
        // A surviving pointer (3) would pick requester 3; a reset pointer picks 0.
        req_valid = 4'b1001;
        #1;
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rstmid_ptr: got %b expected 0001", req_ready); end
        tick();
        req_valid = '0;
        tick();
        n_tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL rstmid_after: got valid=%b id=%0d expected 1/0", rsp_valid, rsp_id); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_stall();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1);
    end

endmodule

// File: doc/addsub_rr_scheduler.md
Name: addsub_rr_scheduler

Overview:
Shares one ripple_carry_adder_subtractor instance (N bits, Cin doubles as subtract select) among NREQ requesters. A round-robin grant picks one request and registers its operands. The shared adder evaluates from those registers, and the result is held on a single valid/ready response port tagged with the requester id. It sits between the ALU issue logic and the adder datapath, and registers the adder's inputs and outputs so the long ripple chain spans one full cycle.

Parameters:
N, 32, operand/result width
NREQ, 4, number of requesters (>=2)

Ports:
clk  input  1  clock; all state changes on posedge
rst  input  1  reset; one clock; reset is asynchronous and active-high
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester grant/accept, one-hot or zero
req_sub  input  NREQ  1 = A-B, 0 = A+B
req_a  input  NREQ*N  operand A, requester i at bits [i*N +: N]
req_b  input  NREQ*N  operand B, same packing
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accepts result
rsp_id  output  clog2(NREQ)  index of the requester that owns the result
rsp_sum  output  N  adder S
rsp_cout  output  1  adder Cout (for sub: 1 = no borrow)

Behaviour:
- States:
  - IDLE: accept a request.
  - EXEC: the adder evaluates registered operands.
  - RESP: the result is held.
- Reset (async, rst=1):
  - State = IDLE, rr pointer = 0.
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_cout = 0, operand registers = 0.
- IDLE:
  - Grant goes to the first requester with req_valid=1, searching upward from the pointer modulo NREQ.
  - req_ready[g] = 1 combinationally in the same cycle. The handshake is req_valid[g] & req_ready[g].
  - On the handshake: latch a, b, sub and the id; pointer <= (g+1) mod NREQ; go to EXEC.
  - No req_valid: stay in IDLE; pointer unchanged.
- EXEC:
  - Adder inputs come only from the operand registers (A, B, Cin=sub).
  - At the clock edge, capture S and Cout into rsp_sum/rsp_cout; go to RESP.
  - req_ready = 0.
- RESP:
  - rsp_valid = 1; rsp_* stable until rsp_ready=1.
  - On rsp_ready, go to IDLE at the next edge.
  - No grant is issued while in RESP.
- Latency and throughput:
  - Handshake at cycle T; rsp_valid first high at cycle T+2.
  - Best-case throughput is 1 operation per 3 cycles.
  - rsp_ready held low stalls indefinitely with no loss.
- Arithmetic:
  - Modulo 2^N; no saturation.
  - Sub is computed as A + ~B + 1 via Cin.
- Boundaries:
  - Requester deasserting req_valid before grant: permitted, nothing latched.
  - All requesters valid continuously: strict rotation 0,1,2,3,0,...
  - Only one requester valid: it is granted every opportunity regardless of pointer.
  - Operand inputs changing after the handshake: no effect.
  - rst mid-EXEC/RESP: operation discarded, no response; pointer returns to 0.

Optional Feature:
- Macro ADDSUB_RR_SCHED_OVF_EN.
- Defined: adds output port rsp_ovf (1 bit), registered in EXEC alongside rsp_sum.
  - Computed as signed overflow: A[N-1]==Bx[N-1] && S[N-1]!=A[N-1], where Bx = B ^ {N{sub}}.
  - Reset to 0; held with the rest of rsp_* in RESP.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package addsub_rr_sched_pkg holds:
  - State enum (IDLE, EXEC, RESP).
  - Localparam ID_W = clog2(NREQ) helper.
  - Response struct {id, sum, cout[, ovf]} sized by N.
- Sub-module rr_arbiter(NREQ): inputs req vector and pointer; outputs one-hot grant and encoded index; purely combinational.
- The top owns the FSM, pointer, operand/result registers and the adder instance.

Test Plan:
- Reset then req 0 valid, a=5, b=7, sub=0 -> req_ready[0] same cycle; 2 cycles later rsp_valid, id=0, sum=12, cout=0.
- Req 1: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0. Then a=7, b=5, sub=1 -> sum=2, cout=1.
- Req 2: a=0xFFFFFFFF, b=1, sub=0 -> sum=0, cout=1. With OVF_EN: a=0x7FFFFFFF, b=1 -> ovf=1; a=0x80000000, b=1, sub=1 -> ovf=1.
- All 4 requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 on cycles T, T+3, T+6, ...; rsp_id matches in order.
- rsp_ready low 10 cycles in RESP -> rsp_* stable, req_ready all 0; on release, next grant one cycle after the RESP->IDLE transition.
- rst asserted during EXEC -> outputs 0 immediately (async); no response emitted; next grant from requester 0 priority.
